// File: rtl/mc_control_unit_if.sv
// Bus between the instruction register/flags side and the datapath controls of
// the multicycle control unit. clk and reset stay outside as plain ports.
interface mc_control_unit_if #(
    parameter int ALUCTL_W = 3
);
    logic [1:0]          Op;
    logic [5:0]          Funct;
    logic [3:0]          Rd;
    logic [3:0]          Instr74;
    // MemReady: memory raises it in the cycle an access completes; FETCH, MEMRD and
    // MEMWR keep their outputs steady until it is sampled high on a rising edge.
    logic                MemReady;
    logic [1:0]          FlagW;
    logic                PCS;
    logic                NextPC;
    logic                RegW;
    logic                MemW;
    logic                IRWrite;
    logic                AdrSrc;
    logic [1:0]          ResultSrc;
    logic [1:0]          ALUSrcA;
    logic [1:0]          ALUSrcB;
    logic [1:0]          ImmSrc;
    logic [1:0]          RegSrc;
    logic [ALUCTL_W-1:0] ALUControl;
    logic                MulStart;
    logic                Undef;
    logic [3:0]          State;

    modport master (
        output Op, Funct, Rd, Instr74, MemReady,
        input  FlagW, PCS, NextPC, RegW, MemW, IRWrite, AdrSrc, ResultSrc,
               ALUSrcA, ALUSrcB, ImmSrc, RegSrc, ALUControl, MulStart, Undef, State
    );

    modport slave (
        input  Op, Funct, Rd, Instr74, MemReady,
        output FlagW, PCS, NextPC, RegW, MemW, IRWrite, AdrSrc, ResultSrc,
               ALUSrcA, ALUSrcB, ImmSrc, RegSrc, ALUControl, MulStart, Undef, State
    );
endinterface

// File: rtl/mc_control_unit.sv
// Multicycle ARM control unit: main FSM with memory wait states and an iterative
// multiply state, ALU/flag decode and PC-source logic.
module mc_control_unit #(
    parameter int ALUCTL_W    = 3,
    parameter int MUL_CYCLES  = 4,
    parameter int MEM_WAIT_EN = 1
) (
    input  logic               clk,
    input  logic               reset,
    mc_control_unit_if.slave   bus
);
    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_MEMADR = 4'd2;
    localparam logic [3:0] S_MEMRD  = 4'd3;
    localparam logic [3:0] S_MEMWB  = 4'd4;
    localparam logic [3:0] S_MEMWR  = 4'd5;
    localparam logic [3:0] S_EXECR  = 4'd6;
    localparam logic [3:0] S_EXECI  = 4'd7;
    localparam logic [3:0] S_ALUWB  = 4'd8;
    localparam logic [3:0] S_BRANCH = 4'd9;
    localparam logic [3:0] S_MULEX  = 4'd10;

    logic [3:0] r_state;
    logic [3:0] r_cnt;
    logic [3:0] w_next;
    logic       w_mem_rdy;
    logic       w_is_mul;
    logic       w_fn_ok;
    logic       w_is_cmp;
    logic       w_is_tst;
    logic       w_arith;
    logic       w_s;
    logic [2:0] w_alu3;
    logic       w_undef;
    logic       w_regw;
    logic       w_branch;

    assign w_mem_rdy = (MEM_WAIT_EN != 0) ? bus.MemReady : 1'b1;
    assign w_is_mul  = (bus.Op == 2'b00) && (bus.Funct[5:4] == 2'b00) && (bus.Instr74 == 4'b1001);
    assign w_is_cmp  = (bus.Funct[4:1] == 4'b1010);
    assign w_is_tst  = (bus.Funct[4:1] == 4'b1000);
    assign w_arith   = (bus.Funct[4:1] == 4'b0100) || (bus.Funct[4:1] == 4'b0010) ||
                       (bus.Funct[4:1] == 4'b0011) || w_is_cmp;
    assign w_s       = bus.Funct[0] | w_is_cmp | w_is_tst;

    always_comb begin
        w_alu3  = 3'b000;
        w_fn_ok = 1'b1;
        case (bus.Funct[4:1])
            4'b0000: w_alu3 = 3'b000;
            4'b0001: w_alu3 = 3'b100;
            4'b0010: w_alu3 = 3'b001;
            4'b0011: w_alu3 = 3'b101;
            4'b0100: w_alu3 = 3'b000;
            4'b1000: w_alu3 = 3'b010;
            4'b1010: w_alu3 = 3'b001;
            4'b1100: w_alu3 = 3'b011;
            4'b1101: w_alu3 = 3'b110;
            default: w_fn_ok = 1'b0;
        endcase
    end

    always_comb begin
        w_next  = r_state;
        w_undef = 1'b0;
        case (r_state)
            S_FETCH:  if (w_mem_rdy) w_next = S_DECODE;
            S_DECODE: begin
                if (bus.Op == 2'b01)      w_next = S_MEMADR;
                else if (bus.Op == 2'b10) w_next = S_BRANCH;
                else if (bus.Op == 2'b11) begin w_undef = 1'b1; w_next = S_FETCH; end
                else if (w_is_mul)        w_next = S_MULEX;
                else if (!w_fn_ok)        begin w_undef = 1'b1; w_next = S_FETCH; end
                else if (bus.Funct[5])    w_next = S_EXECI;
                else                      w_next = S_EXECR;
            end
            S_MEMADR: w_next = bus.Funct[0] ? S_MEMRD : S_MEMWR;
            S_MEMRD:  if (w_mem_rdy) w_next = S_MEMWB;
            S_MEMWR:  if (w_mem_rdy) w_next = S_FETCH;
            S_EXECR,
            S_EXECI:  w_next = S_ALUWB;
            S_MULEX:  if (r_cnt == 4'd0) w_next = S_ALUWB;
            default:  w_next = S_FETCH;
        endcase
    end

    // The counter reloads on MULEX entry, so it equals MUL_CYCLES-1 only in the first cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_FETCH;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_next;
            if (r_state == S_DECODE && w_next == S_MULEX)
                r_cnt <= 4'(MUL_CYCLES - 1);
            else if (r_state == S_MULEX && r_cnt != 4'd0)
                r_cnt <= r_cnt - 4'd1;
        end
    end

    always_comb begin
        bus.FlagW      = 2'b00;
        bus.NextPC     = 1'b0;
        bus.MemW       = 1'b0;
        bus.IRWrite    = 1'b0;
        bus.AdrSrc     = 1'b0;
        bus.ResultSrc  = 2'b00;
        bus.ALUSrcA    = 2'b00;
        bus.ALUSrcB    = 2'b00;
        bus.ImmSrc     = 2'b00;
        bus.RegSrc     = 2'b00;
        bus.ALUControl = '0;
        bus.MulStart   = 1'b0;
        bus.Undef      = 1'b0;
        bus.State      = 4'd0;
        w_regw         = 1'b0;
        w_branch       = 1'b0;
        // Every output is forced low while reset is held, even though the state is FETCH.
        if (reset) begin
            bus.State  = r_state;
            bus.ImmSrc = bus.Op;
            bus.RegSrc = {bus.Op == 2'b01, bus.Op == 2'b10};
            case (r_state)
                S_FETCH: begin
                    bus.ALUSrcA = 2'b01; bus.ALUSrcB = 2'b10; bus.ResultSrc = 2'b10;
                    bus.IRWrite = w_mem_rdy; bus.NextPC = w_mem_rdy;
                end
                S_DECODE: begin
                    bus.ALUSrcA = 2'b01; bus.ALUSrcB = 2'b10; bus.ResultSrc = 2'b10;
                    bus.Undef   = w_undef;
                end
                S_MEMADR: bus.ALUSrcB = 2'b01;
                S_MEMRD:  bus.AdrSrc = 1'b1;
                S_MEMWB:  begin bus.ResultSrc = 2'b01; w_regw = 1'b1; end
                S_MEMWR:  begin bus.AdrSrc = 1'b1; bus.MemW = 1'b1; end
                S_EXECR, S_EXECI: begin
                    bus.ALUSrcB    = (r_state == S_EXECI) ? 2'b01 : 2'b00;
                    bus.ALUControl = ALUCTL_W'(w_alu3);
                    bus.FlagW      = {w_s, w_s & w_arith};
                end
                S_ALUWB: begin
                    bus.ResultSrc = w_is_mul ? 2'b11 : 2'b00;
                    w_regw        = !(w_is_cmp || w_is_tst) || w_is_mul;
                end
                S_BRANCH: begin
                    bus.ALUSrcB = 2'b01; bus.ResultSrc = 2'b10; w_branch = 1'b1;
                end
                S_MULEX:  bus.MulStart = (r_cnt == 4'(MUL_CYCLES - 1));
                default:  ;
            endcase
        end
        bus.RegW = w_regw;
        bus.PCS  = w_branch | ((bus.Rd == 4'hF) & w_regw);
    end
endmodule

// File: tb/tb_mc_control_unit.sv
// Directed bench for mc_control_unit: one task per instruction class, inline checks.
module tb_mc_control_unit;
    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    mc_control_unit_if #(.ALUCTL_W(3)) bus ();

    mc_control_unit #(.ALUCTL_W(3), .MUL_CYCLES(4), .MEM_WAIT_EN(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk_state(input string name, input logic [3:0] exp);
        checks++;
        if (bus.State !== exp) begin
            errors++;
            $display("FAIL %s state got=%0d exp=%0d", name, bus.State, exp);
        end
    endtask

    // Loads an instruction in FETCH and steps through DECODE.
    task automatic fetch_decode(input string name, input logic [1:0] op, input logic [5:0] funct,
                                input logic [3:0] rd, input logic [3:0] i74);
        bus.Op = op; bus.Funct = funct; bus.Rd = rd; bus.Instr74 = i74; bus.MemReady = 1'b1;
        #1;
        chk_state({name, "_fetch"}, 4'd0);
        checks++;
        if ({bus.IRWrite, bus.NextPC, bus.ALUSrcA, bus.ALUSrcB, bus.ResultSrc} !== 8'b11_01_10_10) begin
            errors++;
            $display("FAIL %s_fetch_ctl got=%b exp=11011010", name,
                     {bus.IRWrite, bus.NextPC, bus.ALUSrcA, bus.ALUSrcB, bus.ResultSrc});
        end
        tick();
        chk_state({name, "_decode"}, 4'd1);
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b0; bus.Op = 2'b01; bus.Funct = 6'b011001; bus.Rd = 4'hF;
        bus.Instr74 = 4'b0000; bus.MemReady = 1'b1;
        repeat (2) tick();
        checks++;
        if ({bus.FlagW, bus.PCS, bus.NextPC, bus.RegW, bus.MemW, bus.IRWrite, bus.AdrSrc,
             bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ImmSrc, bus.RegSrc, bus.ALUControl,
             bus.MulStart, bus.Undef, bus.State} !== 30'd0) begin
            errors++;
            $display("FAIL reset_outputs got nonzero state=%0d irwrite=%b immsrc=%b", bus.State,
                     bus.IRWrite, bus.ImmSrc);
        end
        reset = 1'b1;
        #1;
        chk_state("reset_release", 4'd0);
    endtask

    task automatic test_add();
        fetch_decode("add", 2'b00, 6'b001000, 4'd1, 4'b0000);
        chk_state("add_execr", 4'd6);
        checks++;
        if ({bus.RegW, bus.ALUControl, bus.FlagW, bus.ALUSrcB} !== 8'b0_000_00_00) begin
            errors++;
            $display("FAIL add_execr_ctl got=%b exp=00000000",
                     {bus.RegW, bus.ALUControl, bus.FlagW, bus.ALUSrcB});
        end
        tick();
        chk_state("add_aluwb", 4'd8);
        checks++;
        if ({bus.RegW, bus.ResultSrc, bus.PCS} !== 4'b1_00_0) begin
            errors++;
            $display("FAIL add_aluwb_ctl got=%b exp=1000", {bus.RegW, bus.ResultSrc, bus.PCS});
        end
        tick();
        chk_state("add_done", 4'd0);
    endtask

    task automatic test_ldr_wait();
        fetch_decode("ldr", 2'b01, 6'b011001, 4'd2, 4'b0000);
        chk_state("ldr_memadr", 4'd2);
        checks++;
        if ({bus.ALUSrcB, bus.ALUControl, bus.ImmSrc, bus.RegSrc} !== 9'b01_000_01_10) begin
            errors++;
            $display("FAIL ldr_memadr_ctl got=%b exp=010000110",
                     {bus.ALUSrcB, bus.ALUControl, bus.ImmSrc, bus.RegSrc});
        end
        bus.MemReady = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            chk_state("ldr_memrd_wait", 4'd3);
            tick();
        end
        chk_state("ldr_memrd_last", 4'd3);
        checks++;
        if (bus.AdrSrc !== 1'b1) begin
            errors++;
            $display("FAIL ldr_adrsrc got=%b exp=1", bus.AdrSrc);
        end
        bus.MemReady = 1'b1;
        tick();
        chk_state("ldr_memwb", 4'd4);
        checks++;
        if ({bus.ResultSrc, bus.RegW} !== 3'b01_1) begin
            errors++;
            $display("FAIL ldr_memwb_ctl got=%b exp=011", {bus.ResultSrc, bus.RegW});
        end
        tick();
        chk_state("ldr_done", 4'd0);
    endtask

    task automatic test_str_wait();
        int memw_cycles;
        memw_cycles = 0;
        fetch_decode("str", 2'b01, 6'b011000, 4'd3, 4'b0000);
        bus.MemReady = 1'b0;
        tick();
        chk_state("str_memwr", 4'd5);
        for (int i = 0; i < 3; i++) begin
            if (i == 2) bus.MemReady = 1'b1;
            #1;
            if (bus.MemW === 1'b1 && bus.State === 4'd5) memw_cycles++;
            tick();
        end
        checks++;
        if (memw_cycles !== 3) begin
            errors++;
            $display("FAIL str_memw_cycles got=%0d exp=3", memw_cycles);
        end
        chk_state("str_done", 4'd0);
    endtask

    task automatic test_cmp();
        fetch_decode("cmp", 2'b00, 6'b010101, 4'd0, 4'b0000);
        checks++;
        if ({bus.ALUControl, bus.FlagW} !== 5'b001_11) begin
            errors++;
            $display("FAIL cmp_execr got=%b exp=00111", {bus.ALUControl, bus.FlagW});
        end
        tick();
        chk_state("cmp_aluwb", 4'd8);
        checks++;
        if (bus.RegW !== 1'b0) begin
            errors++;
            $display("FAIL cmp_regw got=%b exp=0", bus.RegW);
        end
        tick();
    endtask

    task automatic test_eor_imm();
        fetch_decode("eor", 2'b00, 6'b100011, 4'd4, 4'b0000);
        chk_state("eor_execi", 4'd7);
        checks++;
        if ({bus.ALUControl, bus.FlagW, bus.ALUSrcB} !== 7'b100_10_01) begin
            errors++;
            $display("FAIL eor_execi_ctl got=%b exp=1001001", {bus.ALUControl, bus.FlagW, bus.ALUSrcB});
        end
        repeat (2) tick();
    endtask

    task automatic test_mov_pc();
        fetch_decode("movpc", 2'b00, 6'b011010, 4'hF, 4'b0000);
        checks++;
        if ({bus.ALUControl, bus.FlagW, bus.PCS} !== 6'b110_00_0) begin
            errors++;
            $display("FAIL movpc_execr got=%b exp=110000", {bus.ALUControl, bus.FlagW, bus.PCS});
        end
        tick();
        checks++;
        if ({bus.RegW, bus.PCS} !== 2'b11) begin
            errors++;
            $display("FAIL movpc_aluwb got=%b exp=11", {bus.RegW, bus.PCS});
        end
        tick();
    endtask

    task automatic test_mul();
        int starts;
        starts = 0;
        fetch_decode("mul", 2'b00, 6'b000000, 4'd5, 4'b1001);
        for (int i = 0; i < 4; i++) begin
            chk_state("mul_mulex", 4'd10);
            if (bus.MulStart === 1'b1) starts++;
            if (i == 0) begin
                checks++;
                if (bus.MulStart !== 1'b1) begin
                    errors++;
                    $display("FAIL mul_start_first got=%b exp=1", bus.MulStart);
                end
            end
            tick();
        end
        checks++;
        if (starts !== 1) begin
            errors++;
            $display("FAIL mul_start_pulses got=%0d exp=1", starts);
        end
        chk_state("mul_aluwb", 4'd8);
        checks++;
        if ({bus.ResultSrc, bus.RegW} !== 3'b11_1) begin
            errors++;
            $display("FAIL mul_aluwb_ctl got=%b exp=111", {bus.ResultSrc, bus.RegW});
        end
        tick();
        chk_state("mul_done", 4'd0);
    endtask

    task automatic test_branch();
        fetch_decode("b", 2'b10, 6'b100000, 4'd0, 4'b0000);
        chk_state("b_branch", 4'd9);
        checks++;
        if ({bus.PCS, bus.ALUSrcB, bus.ResultSrc, bus.RegSrc} !== 7'b1_01_10_01) begin
            errors++;
            $display("FAIL b_branch_ctl got=%b exp=1011001",
                     {bus.PCS, bus.ALUSrcB, bus.ResultSrc, bus.RegSrc});
        end
        tick();
        chk_state("b_done", 4'd0);
    endtask

    task automatic test_undef();
        bus.Op = 2'b11; bus.Funct = 6'b000000; bus.MemReady = 1'b1;
        tick();
        chk_state("undef_op_decode", 4'd1);
        checks++;
        if (bus.Undef !== 1'b1) begin
            errors++;
            $display("FAIL undef_op_pulse got=%b exp=1", bus.Undef);
        end
        tick();
        chk_state("undef_op_fetch", 4'd0);
        checks++;
        if (bus.Undef !== 1'b0) begin
            errors++;
            $display("FAIL undef_op_clear got=%b exp=0", bus.Undef);
        end
        bus.Op = 2'b00; bus.Funct = 6'b001010;
        tick();
        checks++;
        if (bus.Undef !== 1'b1) begin
            errors++;
            $display("FAIL undef_funct_pulse got=%b exp=1", bus.Undef);
        end
        tick();
        chk_state("undef_funct_fetch", 4'd0);
    endtask

    task automatic test_reset_mid_memwr();
        fetch_decode("rst", 2'b01, 6'b011000, 4'd3, 4'b0000);
        bus.MemReady = 1'b0;
        tick();
        checks++;
        if (bus.MemW !== 1'b1) begin
            errors++;
            $display("FAIL rst_memw_before got=%b exp=1", bus.MemW);
        end
        reset = 1'b0;
        #1;
        checks++;
        if ({bus.MemW, bus.State} !== 5'd0) begin
            errors++;
            $display("FAIL rst_memw_drop got=%b exp=00000", {bus.MemW, bus.State});
        end
        tick();
        reset = 1'b1;
        #1;
        chk_state("rst_after_release", 4'd0);
        bus.MemReady = 1'b1;
        tick();
        chk_state("rst_resume", 4'd1);
        tick();
    endtask

    initial begin
        test_reset();
        test_add();
        test_ldr_wait();
        test_str_wait();
        test_cmp();
        test_eor_imm();
        test_mov_pc();
        test_mul();
        test_branch();
        test_undef();
        test_reset_mid_memwr();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
